// File: rtl/text_ram_arbiter.sv
// Single-port character RAM arbiter: display fetch beats the clear sequencer, which beats host access.
// A two-stage owner tag follows every slot so the RAM read data reaches whoever issued it.
module text_ram_arbiter #(
  parameter int         COLS           = 48,
  parameter int         ROWS           = 17,
  parameter int         ADDR_W         = 10,
  parameter logic [7:0] FILL           = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_low,
  input  logic              fetch_req,
  input  logic [6:0]        fetch_col,
  input  logic [4:0]        fetch_row,
  output logic [7:0]        char_code,
  output logic              char_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int                CELLS   = COLS * ROWS;
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_W = (ADDR_W + 1)'(CELLS);
  localparam logic [7:0]        COLS_C  = 8'(COLS);
  localparam logic [5:0]        ROWS_C  = 6'(ROWS);

  // HOST_NULL marks an out-of-range host access: acked on time, no RAM cycle behind it
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_HOST,
    OWN_HOST_NULL
  } owner_t;

  owner_t            own0_reg, own1_reg;
  logic              off0_reg, off1_reg;
  logic              hwe0_reg, hwe1_reg;
  logic              host_pend_reg;
  logic              init_reg;
  logic [ADDR_W-1:0] clear_cnt_reg;

  logic              disp_in_range;
  logic              host_in_range;
  logic [ADDR_W-1:0] disp_addr;
  logic              grant_disp;
  logic              grant_clear;
  logic              grant_host;

  always_comb begin
    disp_in_range = fetch_req && ({1'b0, fetch_col} < COLS_C) && ({1'b0, fetch_row} < ROWS_C);
    host_in_range = {1'b0, host_addr} < CELLS_W;
    disp_addr     = ADDR_W'(fetch_row) * COLS_A + ADDR_W'(fetch_col);
    grant_disp    = disp_in_range;
    grant_clear   = !disp_in_range && clear_busy;
    grant_host    = !disp_in_range && !clear_busy && host_req && !host_pend_reg;
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      ram_addr      <= '0;
      ram_we        <= 1'b0;
      ram_wdata     <= '0;
      own0_reg      <= OWN_NONE;
      own1_reg      <= OWN_NONE;
      off0_reg      <= 1'b0;
      off1_reg      <= 1'b0;
      hwe0_reg      <= 1'b0;
      hwe1_reg      <= 1'b0;
      char_code     <= '0;
      char_valid    <= 1'b0;
      host_ack      <= 1'b0;
      host_rdata    <= '0;
      host_pend_reg <= 1'b0;
      clear_busy    <= 1'b0;
      clear_cnt_reg <= '0;
      init_reg      <= 1'b1;
    end else begin
      ram_we <= 1'b0;
      if (grant_disp) begin
        ram_addr <= disp_addr;
      end else if (grant_clear) begin
        ram_addr  <= clear_cnt_reg;
        ram_we    <= 1'b1;
        ram_wdata <= FILL;
      end else if (grant_host && host_in_range) begin
        ram_addr  <= host_addr;
        ram_we    <= host_we;
        ram_wdata <= host_wdata;
      end

      if (grant_disp)
        own0_reg <= OWN_DISP;
      else if (grant_host)
        own0_reg <= host_in_range ? OWN_HOST : OWN_HOST_NULL;
      else
        own0_reg <= OWN_NONE;
      off0_reg <= fetch_req && !disp_in_range;
      hwe0_reg <= host_we;
      own1_reg <= own0_reg;
      off1_reg <= off0_reg;
      hwe1_reg <= hwe0_reg;

      char_valid <= (own1_reg == OWN_DISP) || off1_reg;
      if (own1_reg == OWN_DISP)
        char_code <= ram_rdata;
      else if (off1_reg)
        char_code <= FILL;

      // writes leave host_rdata untouched; off-range reads return zero
      host_ack <= (own1_reg == OWN_HOST) || (own1_reg == OWN_HOST_NULL);
      if (own1_reg == OWN_HOST && !hwe1_reg)
        host_rdata <= ram_rdata;
      else if (own1_reg == OWN_HOST_NULL && !hwe1_reg)
        host_rdata <= '0;

      // the ack cycle itself still blocks the host, so a held request restarts one cycle later
      if (grant_host)
        host_pend_reg <= 1'b1;
      else if (host_ack)
        host_pend_reg <= 1'b0;

      init_reg <= 1'b0;
      if (clear_start || (init_reg && CLEAR_ON_RESET)) begin
        clear_busy    <= 1'b1;
        clear_cnt_reg <= '0;
      end else if (grant_clear) begin
        if (clear_cnt_reg == LAST_A)
          clear_busy <= 1'b0;
        else
          clear_cnt_reg <= clear_cnt_reg + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Randomised bench for text_ram_arbiter: a slot/schedule reference model is compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_text_ram_arbiter;
  localparam int         COLS   = 48;
  localparam int         ROWS   = 17;
  localparam int         ADDR_W = 10;
  localparam int         CELLS  = COLS * ROWS;
  localparam logic [7:0] FILL   = 8'h20;

  logic              clk;
  logic              reset_low;
  logic              fetch_req;
  logic [6:0]        fetch_col;
  logic [4:0]        fetch_row;
  logic [7:0]        char_code;
  logic              char_valid;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;
  logic [7:0]        host_rdata;
  logic              clear_start;
  logic              clear_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  text_ram_arbiter #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .FILL(FILL), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_low(reset_low),
    .fetch_req(fetch_req), .fetch_col(fetch_col), .fetch_row(fetch_row),
    .char_code(char_code), .char_valid(char_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the screen RAM beside the arbiter: registered read, one access per cycle
  logic [7:0] tb_mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) tb_mem[ram_addr] <= ram_wdata;
    ram_rdata <= tb_mem[ram_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory contents are tracked by slot order; results land in a schedule two edges ahead.
  logic [7:0]        mmem [0:1023];
  logic              sched_cv  [4];
  logic [7:0]        sched_cc  [4];
  logic              sched_ack [4];
  logic              sched_upd [4];
  logic [7:0]        sched_rd  [4];
  logic              exp_cv, exp_ack, exp_we, exp_busy;
  logic [7:0]        exp_cc, exp_rd, exp_wd;
  logic [ADDR_W-1:0] exp_addr;
  int                m_cnt, ecnt, h_last, slot_r, slot_w, a;
  logic              m_busy, m_init, h_any, taken, nb;
  int                nc;

  always @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      exp_cv = 0; exp_ack = 0; exp_we = 0; exp_busy = 0;
      exp_cc = 0; exp_rd = 0; exp_wd = 0; exp_addr = 0;
      m_cnt = 0; m_busy = 0; m_init = 1; h_any = 0; h_last = 0; ecnt = 0;
      for (int i = 0; i < 4; i++) begin
        sched_cv[i] = 0; sched_ack[i] = 0; sched_upd[i] = 0; sched_cc[i] = 0; sched_rd[i] = 0;
      end
    end else begin
      slot_r = ecnt % 4;
      slot_w = (ecnt + 2) % 4;
      exp_cv = sched_cv[slot_r];
      if (sched_cv[slot_r]) exp_cc = sched_cc[slot_r];
      exp_ack = sched_ack[slot_r];
      if (sched_upd[slot_r]) exp_rd = sched_rd[slot_r];
      sched_cv[slot_r] = 0; sched_ack[slot_r] = 0; sched_upd[slot_r] = 0;

      exp_we = 0;
      taken = 0;
      if (fetch_req) begin
        sched_cv[slot_w] = 1;
        if (int'(fetch_col) < COLS && int'(fetch_row) < ROWS) begin
          a = int'(fetch_row) * COLS + int'(fetch_col);
          sched_cc[slot_w] = mmem[a];
          exp_addr = ADDR_W'(a);
          taken = 1;
        end else begin
          sched_cc[slot_w] = FILL;
        end
      end
      nb = m_busy;
      nc = m_cnt;
      if (!taken && m_busy) begin
        mmem[m_cnt] = FILL;
        exp_we = 1; exp_addr = ADDR_W'(m_cnt); exp_wd = FILL;
        if (m_cnt == CELLS - 1) nb = 0; else nc = m_cnt + 1;
      end else if (!taken && host_req && (!h_any || ecnt >= h_last + 4)) begin
        h_any = 1;
        h_last = ecnt;
        sched_ack[slot_w] = 1;
        a = int'(host_addr);
        if (a < CELLS) begin
          exp_addr = host_addr;
          if (host_we) begin
            mmem[a] = host_wdata;
            exp_we = 1; exp_wd = host_wdata;
          end else begin
            sched_upd[slot_w] = 1; sched_rd[slot_w] = mmem[a];
          end
        end else if (!host_we) begin
          sched_upd[slot_w] = 1; sched_rd[slot_w] = 8'h00;
        end
      end
      if (clear_start || m_init) begin
        nb = 1; nc = 0;
      end
      m_init = 0;
      m_busy = nb;
      m_cnt = nc;
      exp_busy = m_busy;
      ecnt++;
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (reset_low) begin
      chk("clear_busy", 32'(clear_busy), 32'(exp_busy));
      chk("ram_we", 32'(ram_we), 32'(exp_we));
      chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
      if (exp_we) chk("ram_wdata", 32'(ram_wdata), 32'(exp_wd));
      chk("char_valid", 32'(char_valid), 32'(exp_cv));
      chk("char_code", 32'(char_code), 32'(exp_cc));
      chk("host_ack", 32'(host_ack), 32'(exp_ack));
      chk("host_rdata", 32'(host_rdata), 32'(exp_rd));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic host_op(input logic we, input int addr, input logic [7:0] data,
                         output int lat, output logic we_seen);
    host_req = 1; host_we = we; host_addr = ADDR_W'(addr); host_wdata = data;
    lat = 0; we_seen = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (ram_we) we_seen = 1;
    end while (!host_ack && lat < 2000);
    host_req = 0;
  endtask

  task automatic fetch(input int col, input int row, output int lat,
                       output logic [7:0] code, output logic we_seen);
    fetch_req = 1; fetch_col = 7'(col); fetch_row = 5'(row);
    lat = 0; we_seen = 0;
    do begin
      @(posedge clk); #1;
      fetch_req = 0;
      lat++;
      if (ram_we) we_seen = 1;
    end while (!char_valid && lat < 10);
    code = char_code;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int              busy_n, we_n, bad_seq, lat, since, n, first_a, guard;
    logic [7:0]      code;
    logic            we_seen, ack_early;
    logic [ADDR_W-1:0] saved;

    reset_low = 0; fetch_req = 0; fetch_col = 0; fetch_row = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; clear_start = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_char_valid", 32'(char_valid), 0);
    chk("reset_char_code", 32'(char_code), 0);
    chk("reset_host_ack", 32'(host_ack), 0);
    chk("reset_clear_busy", 32'(clear_busy), 0);
    chk("reset_ram_we", 32'(ram_we), 0);
    chk("reset_ram_addr", 32'(ram_addr), 0);
    reset_low = 1;

    // automatic clear after reset
    busy_n = 0; we_n = 0; bad_seq = 0;
    repeat (840) begin
      @(posedge clk); #1;
      if (clear_busy) busy_n++;
      if (ram_we) begin
        if (int'(ram_addr) != we_n || ram_wdata != FILL) bad_seq++;
        we_n++;
      end
    end
    chk("clear_busy_cycles", 32'(busy_n), 816);
    chk("clear_writes", 32'(we_n), 816);
    chk("clear_write_sequence", 32'(bad_seq), 0);
    $display("clear after reset: busy=%0d writes=%0d", busy_n, we_n);

    host_op(1, 5, 8'h41, lat, we_seen);
    chk("host_write_latency", 32'(lat), 3);
    $display("host write addr=5 data=41 lat=%0d", lat);
    repeat (4) @(posedge clk);
    #1;
    fetch(5, 0, lat, code, we_seen);
    chk("fetch_latency", 32'(lat), 3);
    chk("fetch_code", 32'(code), 32'h41);
    $display("fetch col=5 row=0 code=%02h lat=%0d", code, lat);

    repeat (4) @(posedge clk);
    #1;
    saved = ram_addr;
    fetch(50, 3, lat, code, we_seen);
    chk("offscreen_latency", 32'(lat), 3);
    chk("offscreen_code", 32'(code), 32'(FILL));
    chk("offscreen_ram_addr", 32'(ram_addr), 32'(saved));
    chk("offscreen_no_write", 32'(we_seen), 0);
    $display("fetch col=50 row=3 code=%02h lat=%0d", code, lat);

    repeat (4) @(posedge clk);
    #1;
    host_op(0, 5, 8'h00, lat, we_seen);
    chk("host_read5_data", 32'(host_rdata), 32'h41);
    $display("host read addr=5 data=%02h lat=%0d", host_rdata, lat);
    @(posedge clk); #1;
    host_op(0, 900, 8'h00, lat, we_seen);
    chk("host_read900_latency", 32'(lat), 3);
    chk("host_read900_data", 32'(host_rdata), 0);
    chk("host_read900_no_write", 32'(we_seen), 0);
    $display("host read addr=900 data=%02h lat=%0d", host_rdata, lat);

    // randomized mix of fetches, host traffic and rare clears
    since = 4;
    repeat (3000) begin
      @(posedge clk); #1;
      fetch_req = 0; clear_start = 0;
      since++;
      if (since >= 4 && $urandom_range(0, 1) == 1) begin
        fetch_req = 1;
        fetch_col = 7'($urandom_range(0, 55));
        fetch_row = 5'($urandom_range(0, 19));
        since = 0;
      end
      if (host_req) begin
        if (host_ack) begin
          if ($urandom_range(0, 1) == 1) host_req = 0;
          else begin
            host_we = 1'($urandom_range(0, 1));
            host_addr = ADDR_W'($urandom_range(0, 1023));
            host_wdata = 8'($urandom_range(0, 255));
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        host_req = 1;
        host_we = 1'($urandom_range(0, 1));
        host_addr = ADDR_W'($urandom_range(0, 1023));
        host_wdata = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 999) == 0) clear_start = 1;
    end
    @(posedge clk); #1;
    fetch_req = 0; clear_start = 0;
    if (host_req) begin
      guard = 0;
      while (!host_ack && guard < 2000) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("random_final_ack_timeout", 32'(host_ack), 1);
      host_req = 0;
    end
    $display("random phase done checks=%0d", checks);

    // clear, restart mid-way, with a host read held throughout
    guard = 0;
    while (clear_busy && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    clear_start = 1;
    @(posedge clk); #1;
    clear_start = 0;
    repeat (399) @(posedge clk);
    #1;
    chk("clear_midway_busy", 32'(clear_busy), 1);
    host_req = 1; host_we = 0; host_addr = 10; host_wdata = 0;
    clear_start = 1;
    @(posedge clk); #1;
    clear_start = 0;
    n = 0; first_a = -1; ack_early = 0; guard = 0;
    while (guard < 2000) begin
      @(posedge clk); #1;
      guard++;
      if (ram_we) begin
        if (n == 0) first_a = int'(ram_addr);
        n++;
      end
      if (host_ack) ack_early = 1;
      if (!clear_busy) break;
    end
    chk("restart_first_addr", 32'(first_a), 0);
    chk("restart_writes", 32'(n), 816);
    chk("host_blocked_during_clear", 32'(ack_early), 0);
    lat = 0;
    while (!host_ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    host_req = 0;
    chk("host_after_clear_latency", 32'(lat), 3);
    chk("host_after_clear_data", 32'(host_rdata), 32'(FILL));
    $display("restart clear writes=%0d host ack lat=%0d data=%02h", n, lat, host_rdata);

    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
